// File: rtl/code_tally_pkg.sv
// code_tally_pkg: shared class constants, FSM state type and a class-range
// helper for the code_tally block.
package code_tally_pkg;

    localparam logic [2:0] CLS_MIN = 3'd1;
    localparam logic [2:0] CLS_MAX = 3'd5;
    localparam int         NUM_CLS = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_e;

    // True when a class code names one of the counted classes.
    function automatic logic is_valid_cls(input logic [2:0] code);
        return (code >= CLS_MIN) && (code <= CLS_MAX);
    endfunction

endpackage

// File: rtl/code_tally_if.sv
// code_tally_if: bundles the code input, dump request, readout port and
// status flags of code_tally.
//
// Readout handshake: a beat transfers on a rising clk edge where out_vld and
// out_rdy are both high. While out_vld is high and out_rdy is low the beat
// (out_idx/out_cnt) is held unchanged. out_vld never depends combinationally
// on out_rdy.
interface code_tally_if #(
    parameter int CNT_W = 8
);
    import code_tally_pkg::*;

    logic [2:0]       code_in;
    logic             code_vld;
    logic             dump_req;
    logic             out_rdy;
    logic             out_vld;
    logic [2:0]       out_idx;
    logic [CNT_W-1:0] out_cnt;
    logic             busy;
    logic             err_seen;
    state_e           dbg_state;

    // Producer/consumer side (decoder plus readout sink).
    modport master (
        output code_in, code_vld, dump_req, out_rdy,
        input  out_vld, out_idx, out_cnt, busy, err_seen, dbg_state
    );

    // The tally block itself.
    modport slave (
        input  code_in, code_vld, dump_req, out_rdy,
        output out_vld, out_idx, out_cnt, busy, err_seen, dbg_state
    );

endinterface

// File: rtl/code_tally_counter.sv
// tally_counter: one CNT_W-bit occurrence counter with increment and clear
// (clear wins). Overflow behaviour is selected by CODE_TALLY_SAT_EN:
// defined -> saturate at all-ones, undefined -> wrap.
// nxt_o is the post-increment value ignoring clear, so the parent can
// snapshot the count including a same-cycle increment.
module tally_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] nxt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

`ifdef CODE_TALLY_SAT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`endif

    // Incremented value, then clear applied on top of it.
    always_comb begin
        nxt_o = cnt_q;
        if (inc_i) begin
`ifdef CODE_TALLY_SAT_EN
            if (cnt_q != CNT_MAX) begin
                nxt_o = cnt_q + 1'b1;
            end
`else
            nxt_o = cnt_q + 1'b1;
`endif
        end
        cnt_d = clr_i ? '0 : nxt_o;
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/code_tally.sv
// code_tally: counts class codes 1..5 in live counters and, on dump_req,
// snapshots and clears them, then streams the five snapshot values out as
// registered valid/ready beats. Counting continues during the stream.
// Optional feature macro: CODE_TALLY_SAT_EN (saturating live counters).
module code_tally
    import code_tally_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    code_tally_if.slave bus
);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic [CNT_W-1:0] shadow_q [NUM_CLS];
    logic [CNT_W-1:0] shadow_d [NUM_CLS];
    logic             err_q, err_d;
    logic             accept;
    logic [CNT_W-1:0] nxt [NUM_CLS];
    logic [NUM_CLS-1:0] inc;

    // Live counters; a dump acceptance clears them, the same-cycle code
    // lands in the snapshot through nxt.
    for (genvar g = 0; g < NUM_CLS; g++) begin : g_cnt
        assign inc[g] = bus.code_vld && (bus.code_in == 3'(g + 1));
        tally_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (inc[g]),
            .clr_i (accept),
            .nxt_o (nxt[g])
        );
    end

    // FSM next state, snapshot capture, beat sequencing and error flag.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ocnt_d   = ocnt_q;
        shadow_d = shadow_q;
        accept   = 1'b0;
        err_d    = err_q | (bus.code_vld && !is_valid_cls(bus.code_in));
        case (state_q)
            IDLE: begin
                if (bus.dump_req) begin
                    accept   = 1'b1;
                    state_d  = DUMP;
                    shadow_d = nxt;
                    idx_d    = CLS_MIN;
                    ocnt_d   = nxt[0];
                end
            end
            DUMP: begin
                if (bus.out_rdy) begin
                    if (idx_q == CLS_MAX) begin
                        state_d = IDLE;
                        idx_d   = 3'd0;
                        ocnt_d  = '0;
                    end else begin
                        // Next beat is class idx_q+1, stored at slot idx_q.
                        idx_d  = idx_q + 3'd1;
                        ocnt_d = shadow_q[idx_q];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            ocnt_q  <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < NUM_CLS; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ocnt_q   <= ocnt_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.out_vld   = (state_q == DUMP);
    assign bus.busy      = (state_q == DUMP);
    assign bus.out_idx   = idx_q;
    assign bus.out_cnt   = ocnt_q;
    assign bus.err_seen  = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_code_tally.sv
// tb_code_tally: self-checking bench for code_tally (CNT_W = 2).
module tb_code_tally;
    import code_tally_pkg::*;

    localparam int CNT_W = 2;
    localparam int BW    = 3 + CNT_W;
`ifdef CODE_TALLY_SAT_EN
    localparam logic [CNT_W-1:0] OVF_EXP = 2'd3;
`else
    localparam logic [CNT_W-1:0] OVF_EXP = 2'd2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    code_tally_if #(.CNT_W(CNT_W)) bus ();

    code_tally #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: unbounded per-class totals since the last snapshot,
    // folded into CNT_W bits only when a snapshot is taken.
    int          tot [1:5];
    logic        m_err;
    logic [BW-1:0] exp_q [$];
    int          n_cmp;
    int          n_fail;

    function automatic logic [CNT_W-1:0] fold(input int t);
        int maxv;
        maxv = (1 << CNT_W) - 1;
`ifdef CODE_TALLY_SAT_EN
        return (t > maxv) ? CNT_W'(maxv) : CNT_W'(t);
`else
        return CNT_W'(t % (1 << CNT_W));
`endif
    endfunction

    task automatic model_clear();
        for (int k = 1; k <= 5; k++) tot[k] = 0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    // Apply one cycle of inputs, advance the model, step past the edge.
    task automatic drive(input logic v, input logic [2:0] c, input logic d, input logic r);
        logic busy_now;
        bus.code_vld = v;
        bus.code_in  = c;
        bus.dump_req = d;
        bus.out_rdy  = r;
        busy_now = (exp_q.size() != 0);
        if (v) begin
            if (c >= 3'd1 && c <= 3'd5) tot[c]++;
            else m_err = 1'b1;
        end
        if (!busy_now && d) begin
            for (int k = 1; k <= 5; k++) begin
                exp_q.push_back({3'(k), fold(tot[k])});
                tot[k] = 0;
            end
        end else if (busy_now && r) begin
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.code_vld = 1'($urandom_range(0, 1));
        bus.code_in  = 3'($urandom_range(0, 7));
        bus.dump_req = 1'($urandom_range(0, 1));
        bus.out_rdy  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        n_cmp++;
        if ({bus.out_vld, bus.busy, bus.out_idx, bus.out_cnt, bus.err_seen} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vld=%b busy=%b idx=%0d cnt=%0d err=%b, want all 0",
                     bus.out_vld, bus.busy, bus.out_idx, bus.out_cnt, bus.err_seen);
        end
        n_cmp++;
        if (bus.dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want IDLE", bus.dbg_state);
        end
    endtask

    task automatic test_basic();
        logic [CNT_W-1:0] want [1:5];
        want = '{2'd2, 2'd1, 2'd1, 2'd0, 2'd1};
        do_reset();
        drive(1, 3'd1, 0, 0);
        drive(1, 3'd1, 0, 0);
        drive(1, 3'd2, 0, 0);
        drive(1, 3'd5, 0, 0);
        drive(1, 3'd3, 0, 0);
        drive(0, 3'd0, 1, 1);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if ({bus.out_vld, bus.busy, bus.out_idx, bus.out_cnt} !== {2'b11, 3'(k), want[k]}) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got vld=%b busy=%b idx=%0d cnt=%0d want 1 1 %0d %0d",
                         k, bus.out_vld, bus.busy, bus.out_idx, bus.out_cnt, k, want[k]);
            end
            n_cmp++;
            if ({bus.out_idx, bus.out_cnt} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL basic_model%0d: got %h want %h", k, {bus.out_idx, bus.out_cnt}, exp_q[0]);
            end
            drive(0, 3'd0, 0, 1);
        end
        n_cmp++;
        if ({bus.out_vld, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_done: got vld=%b busy=%b want 0 0", bus.out_vld, bus.busy);
        end
    endtask

    task automatic test_errors();
        do_reset();
        drive(1, 3'd0, 0, 0);
        n_cmp++;
        if (bus.err_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b want 1", bus.err_seen);
        end
        drive(1, 3'd6, 0, 0);
        drive(1, 3'd7, 0, 0);
        drive(0, 3'd0, 1, 1);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if ({bus.out_vld, bus.out_idx, bus.out_cnt} !== {1'b1, 3'(k), 2'd0}) begin
                n_fail++;
                $display("FAIL err_beat%0d: got vld=%b idx=%0d cnt=%0d want 1 %0d 0",
                         k, bus.out_vld, bus.out_idx, bus.out_cnt, k);
            end
            drive(0, 3'd0, 0, 1);
        end
        for (int k = 0; k < 4; k++) drive(1, 3'd1, 0, 0);
        n_cmp++;
        if (bus.err_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want 1", bus.err_seen);
        end
        do_reset();
        n_cmp++;
        if (bus.err_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: got %b want 0", bus.err_seen);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(1, 3'd4, 1, 1);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if ({bus.out_vld, bus.out_idx, bus.out_cnt} !== {1'b1, 3'(k), (k == 4) ? 2'd1 : 2'd0}) begin
                n_fail++;
                $display("FAIL same_first%0d: got vld=%b idx=%0d cnt=%0d want class4=1 others 0",
                         k, bus.out_vld, bus.out_idx, bus.out_cnt);
            end
            drive(0, 3'd0, 0, 1);
        end
        drive(0, 3'd0, 1, 1);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if ({bus.out_vld, bus.out_idx, bus.out_cnt} !== {1'b1, 3'(k), 2'd0}) begin
                n_fail++;
                $display("FAIL same_second%0d: got vld=%b idx=%0d cnt=%0d want 1 %0d 0",
                         k, bus.out_vld, bus.out_idx, bus.out_cnt, k);
            end
            drive(0, 3'd0, 0, 1);
        end
    endtask

    task automatic test_backpressure();
        int j;
        logic r;
        do_reset();
        drive(0, 3'd0, 1, 1);
        j = 0;
        while (exp_q.size() != 0 && j < 40) begin
            r = (j % 4 == 0) || (j % 4 == 3);
            n_cmp++;
            if ({bus.out_vld, bus.busy, bus.out_idx, bus.out_cnt} !== {2'b11, exp_q[0]}) begin
                n_fail++;
                $display("FAIL bp_beat cyc%0d: got vld=%b busy=%b idx=%0d cnt=%0d want 1 1 %h",
                         j, bus.out_vld, bus.busy, bus.out_idx, bus.out_cnt, exp_q[0]);
            end
            drive(j < 3, 3'd2, exp_q.size() > 1, r);
            j++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || bus.out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got vld=%b pending=%0d want 0 0", bus.out_vld, exp_q.size());
        end
        drive(0, 3'd0, 1, 1);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if ({bus.out_vld, bus.out_idx, bus.out_cnt} !== {1'b1, 3'(k), (k == 2) ? 2'd3 : 2'd0}) begin
                n_fail++;
                $display("FAIL bp_next%0d: got vld=%b idx=%0d cnt=%0d want class2=3 others 0",
                         k, bus.out_vld, bus.out_idx, bus.out_cnt);
            end
            drive(0, 3'd0, 0, 1);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 6; k++) drive(1, 3'd3, 0, 0);
        drive(0, 3'd0, 1, 1);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if ({bus.out_vld, bus.out_idx, bus.out_cnt} !== {1'b1, 3'(k), (k == 3) ? OVF_EXP : 2'd0}) begin
                n_fail++;
                $display("FAIL ovf_beat%0d: got vld=%b idx=%0d cnt=%0d want class3=%0d others 0",
                         k, bus.out_vld, bus.out_idx, bus.out_cnt, OVF_EXP);
            end
            drive(0, 3'd0, 0, 1);
        end
    endtask

    task automatic test_reset_mid_dump();
        do_reset();
        drive(1, 3'd1, 0, 0);
        drive(1, 3'd2, 0, 0);
        drive(1, 3'd3, 0, 0);
        drive(0, 3'd0, 1, 1);
        drive(0, 3'd0, 0, 1);
        drive(0, 3'd0, 0, 1);
        n_cmp++;
        if ({bus.out_vld, bus.out_idx, bus.out_cnt} !== {1'b1, 3'd3, 2'd1}) begin
            n_fail++;
            $display("FAIL mid_beat3: got vld=%b idx=%0d cnt=%0d want 1 3 1",
                     bus.out_vld, bus.out_idx, bus.out_cnt);
        end
        drive(1, 3'd1, 0, 0);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({bus.out_vld, bus.busy, bus.out_idx, bus.out_cnt} !== '0) begin
                n_fail++;
                $display("FAIL mid_abort%0d: got vld=%b busy=%b idx=%0d cnt=%0d want all 0",
                         k, bus.out_vld, bus.busy, bus.out_idx, bus.out_cnt);
            end
            drive(0, 3'd0, 0, 1);
        end
        drive(0, 3'd0, 1, 1);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if ({bus.out_vld, bus.out_idx, bus.out_cnt} !== {1'b1, 3'(k), 2'd0}) begin
                n_fail++;
                $display("FAIL mid_zero%0d: got vld=%b idx=%0d cnt=%0d want 1 %0d 0",
                         k, bus.out_vld, bus.out_idx, bus.out_cnt, k);
            end
            drive(0, 3'd0, 0, 1);
        end
    endtask

    task automatic test_random();
        logic exp_vld;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            exp_vld = (exp_q.size() != 0);
            n_cmp++;
            if (bus.out_vld !== exp_vld || bus.busy !== exp_vld) begin
                n_fail++;
                $display("FAIL rand_vld cyc%0d: got vld=%b busy=%b want %b", i, bus.out_vld, bus.busy, exp_vld);
            end
            if (exp_vld) begin
                n_cmp++;
                if ({bus.out_idx, bus.out_cnt} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_beat cyc%0d: got idx=%0d cnt=%0d want %h",
                             i, bus.out_idx, bus.out_cnt, exp_q[0]);
                end
            end
            n_cmp++;
            if (bus.err_seen !== m_err) begin
                n_fail++;
                $display("FAIL rand_err cyc%0d: got %b want %b", i, bus.err_seen, m_err);
            end
            drive(1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(1, 5)),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        bus.code_vld = 1'b0;
        bus.code_in  = 3'd0;
        bus.dump_req = 1'b0;
        bus.out_rdy  = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_errors();
        test_same_cycle();
        test_backpressure();
        test_overflow();
        test_reset_mid_dump();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
